// File: rtl/program_loader.sv
// program_loader: synchronises the external load pins and replays each strobed
// byte onto the CPU bus as a MAR-address / MAR-data / RAM-write sequence.
module program_loader #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_mode,
  input  logic              strobe,
  input  logic [7:0]        data_in,
  output logic [7:0]        bus_out,
  output logic              bus_oe,
  output logic              n_load_addr,
  output logic              n_load_data,
  output logic              ram_we_n,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] wr_addr
);

  // state | meaning
  // IDLE  | waiting for a strobe edge while in load mode
  // ADDR  | wr_addr driven on bus, MAR address load low
  // DATA  | latched byte driven on bus, MAR data load low
  // WRITE | bus released, RAM write pulse low
  typedef enum logic [1:0] {IDLE, ADDR, DATA, WRITE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] load_sync_q, load_sync_d;
  logic [SYNC_STAGES-1:0] strobe_sync_q, strobe_sync_d;
  logic                   strobe_prev_q, strobe_prev_d;
  logic [7:0]             byte_q, byte_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic                   done_q, done_d;
  logic                   overflow_q, overflow_d;
  logic [7:0]             bus_out_q, bus_out_d;
  logic                   bus_oe_q, bus_oe_d;
  logic                   n_load_addr_q, n_load_addr_d;
  logic                   n_load_data_q, n_load_data_d;
  logic                   ram_we_n_q, ram_we_n_d;

  logic load_mode_s;
  logic strobe_s;
  logic strobe_rise;

  assign load_mode_s = load_sync_q[SYNC_STAGES-1];
  assign strobe_s    = strobe_sync_q[SYNC_STAGES-1];
  assign strobe_rise = strobe_s && !strobe_prev_q;

  always_comb begin
    load_sync_d   = (load_sync_q << 1) | SYNC_STAGES'(load_mode);
    strobe_sync_d = (strobe_sync_q << 1) | SYNC_STAGES'(strobe);
    strobe_prev_d = strobe_s;
    state_d       = state_q;
    byte_d        = byte_q;
    wr_addr_d     = wr_addr_q;
    done_d        = done_q;
    overflow_d    = overflow_q;

    // Leaving load mode aborts any partial sequence and rearms the loader.
    if (!load_mode_s) begin
      state_d    = IDLE;
      wr_addr_d  = '0;
      done_d     = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if (strobe_rise && (state_q != IDLE || done_q))
        overflow_d = 1'b1;
      case (state_q)
        IDLE: begin
          if (strobe_rise && !done_q) begin
            byte_d  = data_in;
            state_d = ADDR;
          end
        end
        ADDR:  state_d = DATA;
        DATA:  state_d = WRITE;
        WRITE: begin
          state_d   = IDLE;
          wr_addr_d = wr_addr_q + ADDR_W'(1);
          if (&wr_addr_q)
            done_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they line up with it in time.
    bus_out_d = '0;
    case (state_d)
      ADDR:    bus_out_d[ADDR_W-1:0] = wr_addr_d;
      DATA:    bus_out_d = byte_d;
      default: bus_out_d = '0;
    endcase
    bus_oe_d      = (state_d == ADDR) || (state_d == DATA);
    n_load_addr_d = (state_d != ADDR);
    n_load_data_d = (state_d != DATA);
    ram_we_n_d    = (state_d != WRITE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      load_sync_q   <= '0;
      strobe_sync_q <= '0;
      strobe_prev_q <= 1'b0;
      byte_q        <= '0;
      wr_addr_q     <= '0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
      bus_out_q     <= '0;
      bus_oe_q      <= 1'b0;
      n_load_addr_q <= 1'b1;
      n_load_data_q <= 1'b1;
      ram_we_n_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      load_sync_q   <= load_sync_d;
      strobe_sync_q <= strobe_sync_d;
      strobe_prev_q <= strobe_prev_d;
      byte_q        <= byte_d;
      wr_addr_q     <= wr_addr_d;
      done_q        <= done_d;
      overflow_q    <= overflow_d;
      bus_out_q     <= bus_out_d;
      bus_oe_q      <= bus_oe_d;
      n_load_addr_q <= n_load_addr_d;
      n_load_data_q <= n_load_data_d;
      ram_we_n_q    <= ram_we_n_d;
    end
  end

  assign bus_out     = bus_out_q;
  assign bus_oe      = bus_oe_q;
  assign n_load_addr = n_load_addr_q;
  assign n_load_data = n_load_data_q;
  assign ram_we_n    = ram_we_n_q;
  assign cpu_hold    = load_mode_s;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign overflow    = overflow_q;
  assign wr_addr     = wr_addr_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed checks of the loader's bus sequence, sticky flags,
// abort on load-mode exit, strobe gating and asynchronous reset.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_mode = 1'b0;
  logic       strobe = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       n_load_addr;
  logic       n_load_data;
  logic       ram_we_n;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       overflow;
  logic [3:0] wr_addr;

  int checks = 0;
  int failures = 0;
  int oe_count = 0;
  int we_count = 0;
  int oe0, we0;

  program_loader #(.ADDR_W(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .load_mode(load_mode), .strobe(strobe), .data_in(data_in),
    .bus_out(bus_out), .bus_oe(bus_oe), .n_load_addr(n_load_addr), .n_load_data(n_load_data),
    .ram_we_n(ram_we_n), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .overflow(overflow), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_oe === 1'b1) oe_count++;
    if (ram_we_n === 1'b0) we_count++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_bus_out"}, bus_out, 8'h00);
    check({tag, "_bus_oe"}, bus_oe, 1'b0);
    check({tag, "_n_load_addr"}, n_load_addr, 1'b1);
    check({tag, "_n_load_data"}, n_load_data, 1'b1);
    check({tag, "_ram_we_n"}, ram_we_n, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  // One full byte: strobe set just before edge E0, ADDR visible after E0+2.
  task automatic write_byte(input logic [7:0] d, input logic [3:0] a);
    data_in = d;
    strobe  = 1'b1;
    tick(3);
    check("addr_oe", bus_oe, 1'b1);
    check("addr_bus", bus_out, {4'h0, a});
    check("addr_nla", n_load_addr, 1'b0);
    check("addr_nld", n_load_data, 1'b1);
    tick(1);
    check("data_oe", bus_oe, 1'b1);
    check("data_bus", bus_out, d);
    check("data_nld", n_load_data, 1'b0);
    check("data_nla", n_load_addr, 1'b1);
    tick(1);
    check("write_we", ram_we_n, 1'b0);
    check("write_oe", bus_oe, 1'b0);
    check("write_nld", n_load_data, 1'b1);
    tick(1);
    check("post_we", ram_we_n, 1'b1);
    check("post_busy", busy, 1'b0);
    check("post_wr_addr", wr_addr, 4'(a + 4'd1));
    strobe = 1'b0;
    tick(2);
  endtask

  initial begin
    // Reset values
    #1 rst = 1'b1;
    #1;
    check_idle_outputs("rst");
    check("rst_cpu_hold", cpu_hold, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_wr_addr", wr_addr, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    tick(2);

    // Gating: strobe without load mode does nothing
    data_in = 8'h99;
    strobe  = 1'b1;
    tick(4);
    strobe  = 1'b0;
    tick(4);
    check("gate_oe_count", oe_count, 0);
    check("gate_we_count", we_count, 0);
    check("gate_overflow", overflow, 1'b0);
    check("gate_wr_addr", wr_addr, 4'h0);
    check("gate_cpu_hold", cpu_hold, 1'b0);

    // cpu_hold follows load_mode after two edges
    load_mode = 1'b1;
    tick(1);
    check("hold_lat1", cpu_hold, 1'b0);
    tick(1);
    check("hold_lat2", cpu_hold, 1'b1);
    tick(1);

    // Single byte 0xA5 to address 0
    write_byte(8'hA5, 4'h0);
    check("single_we_count", we_count, 1);

    // Overrun: second rise lands while busy with byte at address 1
    we0     = we_count;
    data_in = 8'h5A;
    strobe  = 1'b1;
    tick(2);
    strobe  = 1'b0;
    tick(1);
    check("ovr_addr_bus", bus_out, 8'h01);
    check("ovr_addr_oe", bus_oe, 1'b1);
    strobe  = 1'b1;
    tick(1);
    check("ovr_data_bus", bus_out, 8'h5A);
    tick(3);
    check("ovr_busy", busy, 1'b0);
    check("ovr_wr_addr", wr_addr, 4'h2);
    check("ovr_flag", overflow, 1'b1);
    strobe = 1'b0;
    tick(3);
    check("ovr_single_write", we_count - we0, 1);
    check("ovr_no_restart", busy, 1'b0);

    // Abort: load_mode_s falls while byte 3 is in DATA
    we0     = we_count;
    data_in = 8'h77;
    strobe  = 1'b1;
    tick(2);
    load_mode = 1'b0;
    tick(1);
    check("abort_addr_nla", n_load_addr, 1'b0);
    check("abort_addr_bus", bus_out, 8'h02);
    tick(1);
    check("abort_data_bus", bus_out, 8'h77);
    check("abort_cpu_hold", cpu_hold, 1'b0);
    tick(1);
    check_idle_outputs("abort");
    check("abort_wr_addr", wr_addr, 4'h0);
    check("abort_done", done, 1'b0);
    check("abort_overflow", overflow, 1'b0);
    strobe = 1'b0;
    tick(3);
    check("abort_no_write", we_count - we0, 0);

    // Full program: 16 bytes 0x10..0x1F to addresses 0..15
    load_mode = 1'b1;
    tick(3);
    check("full_start_done", done, 1'b0);
    for (int i = 0; i < 16; i++) begin
      write_byte(8'(8'h10 + i), 4'(i));
      if (i == 14) check("full_done_early", done, 1'b0);
    end
    check("full_done", done, 1'b1);
    check("full_wr_addr", wr_addr, 4'h0);
    check("full_overflow_clear", overflow, 1'b0);

    // 17th strobe is dropped
    oe0     = oe_count;
    we0     = we_count;
    data_in = 8'hFF;
    strobe  = 1'b1;
    tick(6);
    strobe  = 1'b0;
    tick(3);
    check("extra_no_oe", oe_count - oe0, 0);
    check("extra_no_we", we_count - we0, 0);
    check("extra_overflow", overflow, 1'b1);
    check("extra_done", done, 1'b1);
    check_idle_outputs("extra");

    // Leaving load mode clears the sticky flags
    load_mode = 1'b0;
    tick(3);
    check("exit_done", done, 1'b0);
    check("exit_overflow", overflow, 1'b0);
    check("exit_wr_addr", wr_addr, 4'h0);
    check("exit_cpu_hold", cpu_hold, 1'b0);

    // Asynchronous reset in the middle of DATA
    load_mode = 1'b1;
    tick(3);
    data_in = 8'hC3;
    strobe  = 1'b1;
    tick(4);
    check("prerst_oe", bus_oe, 1'b1);
    check("prerst_bus", bus_out, 8'hC3);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    check("async_rst_cpu_hold", cpu_hold, 1'b0);
    check("async_rst_wr_addr", wr_addr, 4'h0);
    strobe = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    check("post_rst_wr_addr", wr_addr, 4'h0);
    check("post_rst_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
